accel_host_driver: RTL and testbench
====================================

ACCEL_HOST_DRIVER -- requirements
Module: accel_host_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the operand/result width of the modular-arithmetic accelerator.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the wait-state watchdog limit (used only under REQ-030).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 bus_sel  input  1  CPU access strobe, one cycle per access.
REQ-006 bus_we  input  1  1 = write, 0 = read.
REQ-007 bus_addr  input  3  word index: 0 A, 1 B, 2 MOD, 3 CTRL, 4 STATUS, 5 RESULT.
REQ-008 bus_wdata  input  32  write data; low DATA_WIDTH bits used for A/B/MOD.
REQ-009 bus_rdata  output  32  read data, registered, valid cycle after bus_sel.
REQ-010 irq  output  1  level interrupt, high while STATUS.done=1 and CTRL.ie=1.
REQ-011 acc_a, acc_b, acc_modulant  output  DATA_WIDTH each  operand registers driven straight to accelerator.
REQ-012 acc_control  output  3  opcode to accelerator (000 add, 001 sub, 010 mod, 011 R setup, 100 mult, 101 exp).
REQ-013 acc_start  output  1  one-cycle start pulse.
REQ-014 acc_result  input  DATA_WIDTH  accelerator result.
REQ-015 acc_finished  input  1  accelerator completion level.

Function
REQ-016 CTRL write: bits[2:0] op, bit 4 ie, bit 8 go (self-clearing), bit 9 done-clear (self-clearing); STATUS read: bit0 busy, bit1 done, bit2 rs_valid, bit3 err, zero-extended.
REQ-017 FSM states SHALL be IDLE, RS_START, RS_SETTLE, RS_WAIT, OP_START, OP_SETTLE, OP_WAIT, COMPLETE.
REQ-018 IDLE + go with op in {000,001,010} -> OP_START; op in {100,101} -> RS_START if rs_valid=0, else OP_START; op in {011,110,111} -> no start, err=1, done=1, stay IDLE.
REQ-019 *_START states SHALL assert acc_start for exactly one cycle with acc_control held at the state's opcode (011 for RS_*, latched op for OP_*) from START through WAIT.
REQ-020 *_SETTLE SHALL last exactly one cycle and ignore acc_finished (stale-done guard); *_WAIT exits on acc_finished=1.
REQ-021 RS_WAIT exit SHALL set rs_valid=1 and go to OP_START; OP_WAIT exit SHALL capture acc_result into RESULT zero-extended and go to COMPLETE.
REQ-022 COMPLETE SHALL set done=1, clear busy, return to IDLE next cycle; minimum go-to-done latency for add/sub is 4 cycles.
REQ-023 busy=1 in every state except IDLE; go while busy SHALL be ignored, no error.
REQ-024 Writes to A/B/MOD while busy SHALL be ignored; MOD write when idle SHALL clear rs_valid.
REQ-025 go SHALL clear done and err at acceptance; done-clear and go in same write: go wins (done cleared, op launched).
REQ-026 Reads of unused indices 6-7 SHALL return 0; writes to STATUS/RESULT/unused SHALL be ignored.
REQ-027 Read of RESULT while busy SHALL return previous result.

Reset
REQ-028 rst_n low SHALL force IDLE, A/B/MOD/RESULT/op = 0, ie/done/err/rs_valid = 0, acc_start=0, acc_control=000, bus_rdata=0, irq=0, including mid-operation; no pending op resumes.

Configuration
REQ-029 Macro ACCEL_TIMEOUT_EN selects the watchdog.
REQ-030 With ACCEL_TIMEOUT_EN: counter runs in RS_WAIT/OP_WAIT; reaching TIMEOUT_CYCLES sets err=1, done=1, rs_valid unchanged (RS timeout leaves 0), goes to IDLE, RESULT untouched. Without: WAIT states wait indefinitely, err only from REQ-018.

Structure
REQ-031 Shared package accel_pkg SHALL hold opcode constants, register index constants, CTRL/STATUS bit positions and the FSM state enum.
REQ-032 Single module, no sub-modules; the register file and FSM live in the same block.

Verification
REQ-033 A=5,B=7,MOD=11, op 000 go, finished tied high -> acc_start one pulse, done after 4 cycles, RESULT=1.
REQ-034 MOD=13 fresh, op 100 go -> acc_control 011 pulse first, then 100 pulse; rs_valid=1; second mult go issues only 100.
REQ-035 finished held high from prior op, op 101 go with finished dropping after start, rising 20 cycles later -> RESULT captured only after 20-cycle wait, not at SETTLE.
REQ-036 go op 110 -> no acc_start, STATUS err=1 done=1; go during busy and MOD write during busy ignored.
REQ-037 rst_n low in OP_WAIT -> all outputs reset values same cycle; with ACCEL_TIMEOUT_EN, TIMEOUT_CYCLES=16 and finished stuck low -> err=1 after 16 WAIT cycles, irq=1 if ie=1.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the modular-arithmetic accelerator host driver:
// opcodes, register word indices, CTRL/STATUS bit positions and FSM states.
package accel_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MOD    = 3'b010;
  localparam logic [2:0] OP_RSETUP = 3'b011;
  localparam logic [2:0] OP_MULT   = 3'b100;
  localparam logic [2:0] OP_EXP    = 3'b101;

  localparam logic [2:0] REG_A      = 3'd0;
  localparam logic [2:0] REG_B      = 3'd1;
  localparam logic [2:0] REG_MOD    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_RESULT = 3'd5;

  localparam int CTRL_IE_BIT   = 4;
  localparam int CTRL_GO_BIT   = 8;
  localparam int CTRL_DCLR_BIT = 9;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_RSV_BIT  = 2;
  localparam int STAT_ERR_BIT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RS_START,
    ST_RS_SETTLE,
    ST_RS_WAIT,
    ST_OP_START,
    ST_OP_SETTLE,
    ST_OP_WAIT,
    ST_COMPLETE
  } state_e;

  // Montgomery-style ops need the R constant computed once per modulus.
  function automatic logic op_needs_rs(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_EXP);
  endfunction

endpackage

// File: rtl/accel_host_driver.sv
// CPU-facing register file and sequencing FSM for the modular-arithmetic accelerator.
// Optional wait-state watchdog enabled by defining ACCEL_TIMEOUT_EN.
module accel_host_driver
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_sel,
  input  logic                  bus_we,
  input  logic [2:0]            bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] acc_a,
  output logic [DATA_WIDTH-1:0] acc_b,
  output logic [DATA_WIDTH-1:0] acc_modulant,
  output logic [2:0]            acc_control,
  output logic                  acc_start,
  input  logic [DATA_WIDTH-1:0] acc_result,
  input  logic                  acc_finished,
  output state_e                dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Bus handshake: bus_sel is a one-cycle strobe with no ready/stall; every
  // access completes, and read data appears on bus_rdata the following cycle.

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, mod_q, mod_d, result_q, result_d;
  logic [2:0]            op_q, op_d;
  logic                  ie_q, ie_d, done_q, done_d, err_q, err_d, rsv_q, rsv_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic        idle, wr, rd, go, tmo_hit;
  logic [2:0]  new_op;
  logic [31:0] status_word;
  logic        unused_wdata;

  assign idle   = (state_q == ST_IDLE);
  assign wr     = bus_sel & bus_we;
  assign rd     = bus_sel & ~bus_we;
  assign new_op = bus_wdata[2:0];
  assign go     = wr && (bus_addr == REG_CTRL) && bus_wdata[CTRL_GO_BIT] && idle;
  assign unused_wdata = ^bus_wdata[31:10];

`ifdef ACCEL_TIMEOUT_EN
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mod_d    = mod_q;
    result_d = result_q;
    op_d     = op_q;
    ie_d     = ie_q;
    done_d   = done_q;
    err_d    = err_q;
    rsv_d    = rsv_q;
    rdata_d  = rdata_q;
    tmo_d    = '0;

    status_word = '0;
    status_word[STAT_BUSY_BIT] = ~idle;
    status_word[STAT_DONE_BIT] = done_q;
    status_word[STAT_RSV_BIT]  = rsv_q;
    status_word[STAT_ERR_BIT]  = err_q;

    // Register writes first; FSM updates below take priority on shared flags.
    if (wr) begin
      case (bus_addr)
        REG_A:   if (idle) a_d = bus_wdata[DATA_WIDTH-1:0];
        REG_B:   if (idle) b_d = bus_wdata[DATA_WIDTH-1:0];
        REG_MOD: if (idle) begin
          mod_d = bus_wdata[DATA_WIDTH-1:0];
          rsv_d = 1'b0;
        end
        REG_CTRL: begin
          ie_d = bus_wdata[CTRL_IE_BIT];
          if (bus_wdata[CTRL_DCLR_BIT]) done_d = 1'b0;
          if (idle) op_d = new_op;
        end
        default: ;
      endcase
    end

    if (rd) begin
      case (bus_addr)
        REG_A:      rdata_d = 32'(a_q);
        REG_B:      rdata_d = 32'(b_q);
        REG_MOD:    rdata_d = 32'(mod_q);
        REG_CTRL:   rdata_d = {27'd0, ie_q, 1'b0, op_q};
        REG_STATUS: rdata_d = status_word;
        REG_RESULT: rdata_d = 32'(result_q);
        default:    rdata_d = '0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          case (new_op)
            OP_ADD, OP_SUB, OP_MOD: state_d = ST_OP_START;
            OP_MULT, OP_EXP:        state_d = rsv_q ? ST_OP_START : ST_RS_START;
            default: begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end
          endcase
        end
      end
      ST_RS_START:  state_d = ST_RS_SETTLE;
      // SETTLE ignores acc_finished, which may still be high from the last op.
      ST_RS_SETTLE: state_d = ST_RS_WAIT;
      ST_RS_WAIT: begin
        if (acc_finished) begin
          rsv_d   = 1'b1;
          state_d = ST_OP_START;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_OP_START:  state_d = ST_OP_SETTLE;
      ST_OP_SETTLE: state_d = ST_OP_WAIT;
      ST_OP_WAIT: begin
        if (acc_finished) begin
          result_d = acc_result;
          state_d  = ST_COMPLETE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_COMPLETE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mod_q    <= '0;
      result_q <= '0;
      op_q     <= OP_ADD;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rsv_q    <= 1'b0;
      rdata_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      op_q     <= op_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rsv_q    <= rsv_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    acc_control = OP_ADD;
    case (state_q)
      ST_RS_START, ST_RS_SETTLE, ST_RS_WAIT: acc_control = OP_RSETUP;
      ST_OP_START, ST_OP_SETTLE, ST_OP_WAIT: acc_control = op_q;
      default:                               acc_control = OP_ADD;
    endcase
  end

  assign acc_start    = (state_q == ST_RS_START) || (state_q == ST_OP_START);
  assign acc_a        = a_q;
  assign acc_b        = b_q;
  assign acc_modulant = mod_q;
  assign bus_rdata    = rdata_q;
  assign irq          = done_q & ie_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_accel_host_driver.sv
// Directed self-checking bench for accel_host_driver; the accelerator is modelled
// by bench-driven acc_result/acc_finished with hand-computed results.
module tb_accel_host_driver;
  import accel_pkg::*;

  logic        clk, rst_n;
  logic        bus_sel, bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        irq;
  logic [7:0]  acc_a, acc_b, acc_modulant, acc_result;
  logic [2:0]  acc_control;
  logic        acc_start, acc_finished;
  state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  accel_host_driver #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .irq(irq), .acc_a(acc_a), .acc_b(acc_b), .acc_modulant(acc_modulant),
    .acc_control(acc_control), .acc_start(acc_start), .acc_result(acc_result),
    .acc_finished(acc_finished), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: all are entered and left 1 time unit after a rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk);
    #1;
    bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(posedge clk);
    #1;
    bus_sel = 1'b0;
    d = bus_rdata;
  endtask

  // Writes CTRL, then records start pulses and the edge (counted from the write
  // edge) at which irq first rises; done_cyc = -1 if the budget runs out.
  task automatic run_go(input logic [31:0] ctrl, input int budget, output int pulses,
                        output logic [2:0] ctl0, output logic [2:0] ctl1, output int done_cyc);
    pulses = 0; ctl0 = 3'b111; ctl1 = 3'b111; done_cyc = -1;
    bus_write(REG_CTRL, ctrl);
    if (acc_start) begin ctl0 = acc_control; pulses++; end
    for (int i = 1; i <= budget && done_cyc < 0; i++) begin
      tick(1);
      if (acc_start) begin
        if (pulses == 0) ctl0 = acc_control;
        else if (pulses == 1) ctl1 = acc_control;
        pulses++;
      end
      if (irq) done_cyc = i;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus_rdata !== 32'd0 || irq !== 1'b0 || acc_start !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_bus: rdata=%0h irq=%0b start=%0b expected 0/0/0", bus_rdata, irq, acc_start);
    end
    n_checks++;
    if (acc_control !== 3'b000 || acc_a !== 8'd0 || acc_b !== 8'd0 || acc_modulant !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_acc: ctl=%0b a=%0h b=%0h m=%0h expected all 0", acc_control, acc_a, acc_b, acc_modulant);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_add();
    int p, dc; logic [2:0] c0, c1; logic [31:0] r;
    acc_finished = 1'b1; acc_result = 8'd1;   // (5+7) mod 11
    bus_write(REG_A, 32'd5);
    bus_write(REG_B, 32'd7);
    bus_write(REG_MOD, 32'd11);
    n_checks++;
    if (acc_a !== 8'd5 || acc_b !== 8'd7 || acc_modulant !== 8'd11) begin
      n_errors++;
      $display("FAIL add_operands: a=%0d b=%0d m=%0d expected 5/7/11", acc_a, acc_b, acc_modulant);
    end
    run_go(32'h110, 20, p, c0, c1, dc);
    n_checks++;
    if (p !== 1 || c0 !== OP_ADD) begin
      n_errors++;
      $display("FAIL add_start: pulses=%0d ctl=%0b expected 1/000", p, c0);
    end
    n_checks++;
    if (dc !== 4) begin
      n_errors++;
      $display("FAIL add_latency: done at %0d expected 4", dc);
    end
    bus_read(REG_RESULT, r);
    n_checks++;
    if (r !== 32'd1) begin
      n_errors++;
      $display("FAIL add_result: got %0h expected 1", r);
    end
    bus_read(REG_STATUS, r);
    n_checks++;
    if (r !== 32'h2) begin
      n_errors++;
      $display("FAIL add_status: got %0h expected 2", r);
    end
    bus_write(REG_CTRL, 32'h210);
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++;
      $display("FAIL done_clear_irq: got %0b expected 0", irq);
    end
  endtask

  task automatic test_mult_rs();
    int p, dc; logic [2:0] c0, c1; logic [31:0] r;
    bus_write(REG_MOD, 32'd13);
    acc_result = 8'd9;   // 35 mod 13
    run_go(32'h114, 30, p, c0, c1, dc);
    n_checks++;
    if (p !== 2 || c0 !== OP_RSETUP || c1 !== OP_MULT) begin
      n_errors++;
      $display("FAIL mult_rs_seq: pulses=%0d ctl0=%0b ctl1=%0b expected 2/011/100", p, c0, c1);
    end
    n_checks++;
    if (dc !== 7) begin
      n_errors++;
      $display("FAIL mult_rs_latency: done at %0d expected 7", dc);
    end
    bus_read(REG_STATUS, r);
    n_checks++;
    if (r !== 32'h6) begin
      n_errors++;
      $display("FAIL mult_rs_status: got %0h expected 6", r);
    end
    acc_result = 8'd4;
    // done-clear together with go: go launches the op
    run_go(32'h314, 30, p, c0, c1, dc);
    n_checks++;
    if (p !== 1 || c0 !== OP_MULT || dc !== 4) begin
      n_errors++;
      $display("FAIL mult_second: pulses=%0d ctl=%0b done=%0d expected 1/100/4", p, c0, dc);
    end
    bus_read(REG_RESULT, r);
    n_checks++;
    if (r !== 32'd4) begin
      n_errors++;
      $display("FAIL mult_result: got %0h expected 4", r);
    end
  endtask

  task automatic test_stale_finished();
    int bad, dc; logic [31:0] r;
    acc_finished = 1'b1; acc_result = 8'h33;
    bus_write(REG_CTRL, 32'h115);
    n_checks++;
    if (dbg_state !== ST_OP_START || acc_control !== OP_EXP) begin
      n_errors++;
      $display("FAIL exp_start: state=%0d ctl=%0b expected %0d/101", dbg_state, acc_control, ST_OP_START);
    end
    tick(2);
    n_checks++;
    if (dbg_state !== ST_OP_WAIT) begin
      n_errors++;
      $display("FAIL stale_settle: state=%0d expected %0d", dbg_state, ST_OP_WAIT);
    end
    acc_finished = 1'b0;
    bus_read(REG_RESULT, r);
    n_checks++;
    if (r !== 32'd4) begin
      n_errors++;
      $display("FAIL result_busy: got %0h expected 4", r);
    end
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      tick(1);
      if (dbg_state !== ST_OP_WAIT || acc_control !== OP_EXP || acc_start !== 1'b0 || irq !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL exp_wait_hold: bad cycles=%0d expected 0", bad);
    end
    acc_result = 8'h5A; acc_finished = 1'b1;
    dc = -1;
    for (int i = 1; i <= 10 && dc < 0; i++) begin
      tick(1);
      if (irq) dc = i;
    end
    n_checks++;
    if (dc !== 2) begin
      n_errors++;
      $display("FAIL exp_done: done at %0d expected 2", dc);
    end
    bus_read(REG_RESULT, r);
    n_checks++;
    if (r !== 32'h5A) begin
      n_errors++;
      $display("FAIL exp_result: got %0h expected 5a", r);
    end
  endtask

  task automatic test_invalid_and_busy();
    int st, dc; logic [31:0] r;
    bus_write(REG_CTRL, 32'h116);
    st = acc_start ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (acc_start) st++;
    end
    n_checks++;
    if (st !== 0 || dbg_state !== ST_IDLE || irq !== 1'b1) begin
      n_errors++;
      $display("FAIL invalid_op: starts=%0d state=%0d irq=%0b expected 0/0/1", st, dbg_state, irq);
    end
    bus_read(REG_STATUS, r);
    n_checks++;
    if (r !== 32'hE) begin
      n_errors++;
      $display("FAIL invalid_status: got %0h expected e", r);
    end
    acc_finished = 1'b0;
    bus_write(REG_CTRL, 32'h110);
    tick(2);
    bus_write(REG_CTRL, 32'h111);
    n_checks++;
    if (dbg_state !== ST_OP_WAIT || acc_control !== OP_ADD || acc_start !== 1'b0) begin
      n_errors++;
      $display("FAIL go_busy: state=%0d ctl=%0b start=%0b expected %0d/000/0", dbg_state, acc_control, acc_start, ST_OP_WAIT);
    end
    bus_write(REG_MOD, 32'd3);
    bus_read(REG_STATUS, r);
    n_checks++;
    if (r !== 32'h5) begin
      n_errors++;
      $display("FAIL busy_status: got %0h expected 5", r);
    end
    bus_read(REG_MOD, r);
    n_checks++;
    if (r !== 32'd13 || acc_modulant !== 8'd13) begin
      n_errors++;
      $display("FAIL mod_busy: read=%0h out=%0h expected d/d", r, acc_modulant);
    end
    acc_result = 8'h12; acc_finished = 1'b1;
    dc = -1;
    for (int i = 1; i <= 10 && dc < 0; i++) begin
      tick(1);
      if (irq) dc = i;
    end
    n_checks++;
    if (dc < 0) begin
      n_errors++;
      $display("FAIL busy_op_done: no done within 10 cycles, expected done");
    end
    bus_write(REG_RESULT, 32'hFF);
    bus_write(REG_STATUS, 32'hFF);
    bus_read(REG_RESULT, r);
    n_checks++;
    if (r !== 32'h12) begin
      n_errors++;
      $display("FAIL result_ro: got %0h expected 12", r);
    end
    bus_read(3'd6, r);
    n_checks++;
    if (r !== 32'd0) begin
      n_errors++;
      $display("FAIL unused_read: got %0h expected 0", r);
    end
    bus_read(REG_STATUS, r);
    n_checks++;
    if (r !== 32'h6) begin
      n_errors++;
      $display("FAIL status_ro: got %0h expected 6", r);
    end
  endtask

  task automatic test_reset_mid_op();
    int st; logic [31:0] r;
    acc_finished = 1'b0;
    bus_write(REG_CTRL, 32'h110);
    tick(1);
    bus_read(REG_RESULT, r);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== ST_IDLE || acc_start !== 1'b0 || acc_control !== 3'b000 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_ctl: state=%0d start=%0b ctl=%0b irq=%0b expected 0/0/000/0", dbg_state, acc_start, acc_control, irq);
    end
    n_checks++;
    if (bus_rdata !== 32'd0 || acc_a !== 8'd0 || acc_b !== 8'd0 || acc_modulant !== 8'd0) begin
      n_errors++;
      $display("FAIL midreset_data: rdata=%0h a=%0h b=%0h m=%0h expected all 0", bus_rdata, acc_a, acc_b, acc_modulant);
    end
    acc_finished = 1'b1;
    tick(1);
    rst_n = 1'b1;
    st = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (acc_start || dbg_state !== ST_IDLE) st++;
    end
    n_checks++;
    if (st !== 0) begin
      n_errors++;
      $display("FAIL midreset_resume: bad cycles=%0d expected 0", st);
    end
    bus_read(REG_STATUS, r);
    n_checks++;
    if (r !== 32'd0) begin
      n_errors++;
      $display("FAIL midreset_status: got %0h expected 0", r);
    end
    bus_read(REG_RESULT, r);
    n_checks++;
    if (r !== 32'd0) begin
      n_errors++;
      $display("FAIL midreset_result: got %0h expected 0", r);
    end
  endtask

`ifdef ACCEL_TIMEOUT_EN
  task automatic test_timeout();
    int p, dc; logic [2:0] c0, c1; logic [31:0] r;
    acc_finished = 1'b0;
    run_go(32'h110, 40, p, c0, c1, dc);
    n_checks++;
    if (dc !== 18) begin
      n_errors++;
      $display("FAIL op_timeout: done at %0d expected 18", dc);
    end
    bus_read(REG_STATUS, r);
    n_checks++;
    if (r !== 32'hA) begin
      n_errors++;
      $display("FAIL op_timeout_status: got %0h expected a", r);
    end
    run_go(32'h114, 40, p, c0, c1, dc);
    n_checks++;
    if (dc !== 18 || p !== 1 || c0 !== OP_RSETUP) begin
      n_errors++;
      $display("FAIL rs_timeout: done=%0d pulses=%0d ctl=%0b expected 18/1/011", dc, p, c0);
    end
    bus_read(REG_STATUS, r);
    n_checks++;
    if (r !== 32'hA) begin
      n_errors++;
      $display("FAIL rs_timeout_status: got %0h expected a", r);
    end
    bus_read(REG_RESULT, r);
    n_checks++;
    if (r !== 32'd0) begin
      n_errors++;
      $display("FAIL timeout_result: got %0h expected 0", r);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    acc_result = '0; acc_finished = 1'b0;
    tick(2);
    test_reset();
    rst_n = 1'b1;
    tick(1);
    test_add();
    test_mult_rs();
    test_stale_finished();
    test_invalid_and_busy();
    test_reset_mid_op();
`ifdef ACCEL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
